// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the receiver state encoding, the parity and stop-bit mode codes,
// the oversampling ratio and the line levels used by the transmitter, plus
// small constant helpers used to derive receiver parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int STOP_1   = 1;
    localparam int STOP_2   = 2;
    localparam int STOP_1P5 = 3;

    localparam int OVERSAMPLE = 16;

    // Line levels shared with the transmitter.
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int ovs_div(input int clk_freq, input int baud_rate);
        return (clk_freq + (OVERSAMPLE / 2) * baud_rate) / (OVERSAMPLE * baud_rate);
    endfunction

    // Number of stop bits that are actually sampled. With 1.5 stop bits only
    // the first one is checked, which leaves half a bit of slack for resync.
    function automatic int stop_samples(input int stop_bit);
        case (stop_bit)
            STOP_2:           return 2;
            STOP_1, STOP_1P5: return 1;
            default:          return 1;
        endcase
    endfunction

    // x is the XOR of all data bits and the received parity bit.
    function automatic logic parity_error(input int mode, input logic x);
        case (mode)
            PARITY_ODD:  return ~x;
            PARITY_EVEN: return x;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_ovs_tick.sv
// uart_rx_ovs_tick: free-running divider that emits a one-clock tick every
// OVS_DIV clocks. A synchronous clear restarts the count so the tick phase
// can be aligned to an external event.
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   clear in  restart the division period
//   tick  out one-clock pulse every OVS_DIV clocks
module uart_rx_ovs_tick #(
    parameter int OVS_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVS_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clear || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Synchronises rx, detects the start
// edge, samples each bit at its middle (16 ticks per bit), checks parity and
// stop bits and presents the word with a one-clock valid strobe.
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   rx         in  serial line, idle high
//   data       out last received word (LSB received first)
//   data_valid out one-clock strobe, data and error flags valid
//   parity_err out parity mismatch on the last frame
//   frame_err  out a stop-bit sample read low on the last frame
//   busy       out receiver is inside a frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_BIT = 0,
    parameter int DATA_LEN   = 8,
    parameter int STOP_BIT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [DATA_LEN-1:0] data,
    output logic                data_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy
);

    localparam int OVS_DIV = ovs_div(CLK_FREQ, BAUD_RATE);
    localparam int BW      = $clog2(DATA_LEN + 1);
    localparam int NSTOP   = stop_samples(STOP_BIT);

    uart_state_t state_reg, state_next;

    logic                sync1_reg, rx_s_reg, rx_prev_reg;
    logic [3:0]          tick_cnt_reg;
    logic [BW-1:0]       bit_cnt_reg;
    logic [DATA_LEN-1:0] shift_reg;
    logic                perr_acc_reg, ferr_acc_reg;
    logic [DATA_LEN-1:0] data_reg;
    logic                data_valid_reg, parity_err_reg, frame_err_reg;

    logic tick, fall, sample, start_det, done;

    uart_rx_ovs_tick #(.OVS_DIV(OVS_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (start_det),
        .tick  (tick)
    );

    assign fall   = rx_prev_reg & ~rx_s_reg;
    // The tick counter is zeroed at the start edge and wraps every 16 ticks,
    // so tick 7 is the middle of every bit of the frame.
    assign sample = tick && (tick_cnt_reg == 4'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_det  = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                // An edge coinciding with the strobe cycle is deliberately dropped.
                if (fall && !data_valid_reg) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (sample) begin
                    state_next = (rx_s_reg == START_LEVEL) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (sample && bit_cnt_reg == BW'(DATA_LEN - 1)) begin
                    state_next = (PARITY_BIT != PARITY_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so a following start edge is never missed.
                if (sample && bit_cnt_reg == BW'(NSTOP - 1)) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg      <= LINE_IDLE;
            rx_s_reg       <= LINE_IDLE;
            rx_prev_reg    <= LINE_IDLE;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            perr_acc_reg   <= 1'b0;
            ferr_acc_reg   <= 1'b0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            sync1_reg   <= rx;
            rx_s_reg    <= sync1_reg;
            rx_prev_reg <= rx_s_reg;

            if (start_det) begin
                tick_cnt_reg <= '0;
            end else if (tick && state_reg != IDLE) begin
                tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end

            // Bit counter counts data bits, then is reused for stop bits.
            if (start_det || (state_reg == DATA && state_next != DATA)) begin
                bit_cnt_reg <= '0;
            end else if (sample && (state_reg == DATA || state_reg == STOP)) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            if (sample && state_reg == DATA) begin
                shift_reg <= {rx_s_reg, shift_reg[DATA_LEN-1:1]};
            end

            if (start_det) begin
                perr_acc_reg <= 1'b0;
            end else if (sample && state_reg == PARITY) begin
                perr_acc_reg <= parity_error(PARITY_BIT, (^shift_reg) ^ rx_s_reg);
            end

            if (start_det) begin
                ferr_acc_reg <= 1'b0;
            end else if (sample && state_reg == STOP && !rx_s_reg) begin
                ferr_acc_reg <= 1'b1;
            end

            data_valid_reg <= done;
            if (done) begin
                data_reg       <= shift_reg;
                parity_err_reg <= perr_acc_reg;
                // The final stop sample is folded in here since the
                // accumulator only picks it up on this same edge.
                frame_err_reg  <= ferr_acc_reg | ~rx_s_reg;
            end
        end
    end

    assign data       = data_reg;
    assign data_valid = data_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != IDLE);

endmodule
